tdx_core: RTL and testbench
===========================

TDX_CORE -- requirements
Module: tdx_core

Interface
REQ-001 Parameter DATA_W, default 4, width of A, B, output port, input port and immediate field; legal range 4..16.
REQ-002 Parameter PC_W, default 4, program counter width; legal range 1..DATA_W.
REQ-003 CLK  input  1  system clock; single clock domain; all state changes on rising edge.
REQ-004 RST  input  1  synchronous, active-high reset.
REQ-005 ce  input  1  run-mode execution enable; one instruction per cycle with ce=1.
REQ-006 step_mode  input  1  0 = run mode, 1 = single-step mode.
REQ-007 step_in  input  1  raw asynchronous step button.
REQ-008 in_port  input  DATA_W  external input switches.
REQ-009 prog_addr  output  PC_W  program memory address, equal to the PC register.
REQ-010 prog_data  input  DATA_W+4  instruction at prog_addr, combinational; [DATA_W+3:DATA_W] is the opcode, [DATA_W-1:0] is Im.
REQ-011 out_port  output  DATA_W  registered output port.
REQ-012 reg_a, reg_b  output  DATA_W each  debug view of registers A and B.
REQ-013 carry_o  output  1  carry flag; halted  output  1  halt state; retire  output  1  one-cycle pulse per executed instruction.

Function
REQ-014 exec SHALL be ce when step_mode=0, and a step edge when step_mode=1; ce SHALL be ignored in step mode.
REQ-015 step_in SHALL pass a 2-flop synchronizer, then a rising-edge detect (sync2 & ~prev); the edge detector SHALL run in both modes.
REQ-016 A step_in rise first sampled at edge N SHALL update architectural state at edge N+2; a held-high step_in SHALL yield exactly one exec.
REQ-017 ALU SHALL compute {c, s} = y + Im at DATA_W+1 bits; s wraps modulo 2^DATA_W; c is bit DATA_W.
REQ-018 y SHALL be A for opcodes 0000/0011; B for 0001/0101/1001; in_port for 0010/0110; zero for all other opcodes.
REQ-019 Opcode decode (dest <= s unless stated): 0000 ADD A,Im; 0001 MOV A,B; 0010 IN A; 0011 MOV A,Im; 0100 MOV B,A (y=A, B <= s); 0101 ADD B,Im; 0110 IN B; 0111 MOV B,Im; 1001 OUT B; 1011 OUT Im; 1110 JNC Im; 1111 JMP Im; 1000 HALT; 1010/1100/1101 NOP.
REQ-020 Correction to REQ-018: opcode 0100 SHALL select y=A, and opcodes 0011/0111/1011 SHALL select y=zero.
REQ-021 On each exec, except HALT, carry_o SHALL load c; JNC SHALL test the carry value held before that exec.
REQ-022 JMP, and JNC when carry=0, SHALL load PC <= s[PC_W-1:0]; otherwise PC <= PC+1, wrapping 2^PC_W-1 -> 0.
REQ-023 HALT SHALL hold PC, A, B, out_port and carry, and set halted=1; in the halted state exec SHALL be ignored until RST.
REQ-024 retire SHALL go high for exactly the cycle after each accepted exec, including HALT; retire=0 otherwise.
REQ-025 With exec=0 no architectural state SHALL change.
REQ-026 State machine: RUN --HALT exec--> HALTED; HALTED --RST--> RUN; RST in any state -> RUN.

Reset
REQ-027 With RST=1 at a rising edge: PC, A, B, out_port = 0; carry_o, halted, retire = 0; synchronizer and edge flops = 0.
REQ-028 RST SHALL take priority over exec in the same cycle; RST mid-program SHALL restart at address 0 on the next edge.

Verification (DATA_W=4, PC_W=4 unless stated)
REQ-029 Program 0x33, 0x05, 0x0F, 0xE0, 0x80, run mode, ce=1 -> after 5 retires: A=7, carry=0, PC=4, halted=1; JNC not taken.
REQ-030 in_port=0xA; program 0x60, 0x90, 0xB5 -> out_port=0xA after the 2nd retire, 0x5 after the 3rd; B=0xA.
REQ-031 Program memory all 0xA0 (NOP), 16 execs -> PC returns to 0; registers unchanged; 16 retire pulses.
REQ-032 step_mode=1, ce=1, step_in high for 10 cycles -> exactly one retire, PC 0->1, with the update on the third edge after the rise.
REQ-033 Program halted at PC=4, then RST pulsed for 1 cycle -> next cycle all outputs 0, halted=0; execution resumes from 0.
REQ-034 DATA_W=8, PC_W=4: A=0x02, then ADD A,0xFF -> A=0x01, carry=1; JMP 0x1C -> PC=0xC.

Source files
------------

// File: rtl/tdx_core_if.sv
// Program-memory bus between the core (master) and an instruction store (slave).
interface tdx_core_if #(
  parameter int DATA_W = 4,
  parameter int PC_W   = 4
);
  logic [PC_W-1:0]   prog_addr;
  logic [DATA_W+3:0] prog_data;

  modport master (output prog_addr, input  prog_data);
  modport slave  (input  prog_addr, output prog_data);
endinterface

// File: rtl/tdx_core.sv
// Tiny accumulator CPU: A/B registers, carry, PC, OUT port.
// Executes one instruction per exec, in run mode (ce) or single-step mode.
module tdx_core #(
  parameter int DATA_W = 4,
  parameter int PC_W   = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ce,
  input  logic              step_mode,
  input  logic              step_in,
  input  logic [DATA_W-1:0] in_port,
  tdx_core_if.master        pbus,
  output logic [DATA_W-1:0] out_port,
  output logic [DATA_W-1:0] reg_a,
  output logic [DATA_W-1:0] reg_b,
  output logic              carry_o,
  output logic              halted,
  output logic              retire
);

  typedef enum logic {S_RUN, S_HALTED} state_e;

  state_e            state_q;
  logic [PC_W-1:0]   pc_q;
  logic [DATA_W-1:0] a_q, b_q, out_q;
  logic              carry_q, retire_q;
  logic              sync1_q, sync2_q, prev_q;

  logic [3:0]        opc;
  logic [DATA_W-1:0] imm, y, s;
  logic [DATA_W:0]   sum;
  logic              step_edge, exec, accept;

  // Edge detector runs in both modes so switching into step mode
  // with the button already held does not produce a spurious step.
  assign step_edge = sync2_q & ~prev_q;
  assign exec      = step_mode ? step_edge : ce;
  assign accept    = exec & (state_q == S_RUN);

  assign opc = pbus.prog_data[DATA_W+3:DATA_W];
  assign imm = pbus.prog_data[DATA_W-1:0];

  always_comb begin
    y = '0;
    case (opc)
      4'b0000, 4'b0100:          y = a_q;
      4'b0001, 4'b0101, 4'b1001: y = b_q;
      4'b0010, 4'b0110:          y = in_port;
      default:                   y = '0;
    endcase
  end

  assign sum = {1'b0, y} + {1'b0, imm};
  assign s   = sum[DATA_W-1:0];

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_RUN;
      pc_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      out_q    <= '0;
      carry_q  <= 1'b0;
      retire_q <= 1'b0;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      prev_q   <= 1'b0;
    end else begin
      sync1_q  <= step_in;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      retire_q <= accept;
      if (accept) begin
        if (opc == 4'b1000) begin
          state_q <= S_HALTED;
        end else begin
          carry_q <= sum[DATA_W];
          pc_q    <= pc_q + 1'b1;
          case (opc)
            4'b0000, 4'b0001, 4'b0010, 4'b0011: a_q   <= s;
            4'b0100, 4'b0101, 4'b0110, 4'b0111: b_q   <= s;
            4'b1001, 4'b1011:                   out_q <= s;
            // JNC looks at the carry from the previous instruction.
            4'b1110: if (!carry_q) pc_q <= s[PC_W-1:0];
            4'b1111: pc_q <= s[PC_W-1:0];
            default: ;
          endcase
        end
      end
    end
  end

  assign pbus.prog_addr = pc_q;
  assign out_port       = out_q;
  assign reg_a          = a_q;
  assign reg_b          = b_q;
  assign carry_o        = carry_q;
  assign halted         = (state_q == S_HALTED);
  assign retire         = retire_q;

endmodule

// File: tb/tb_tdx_core.sv
// Scoreboard bench for tdx_core: an instruction-level model predicts state per exec,
// a monitor compares it whenever retire pulses; plus directed step/reset/8-bit checks.
module tb_tdx_core;
  localparam int DW = 4, PW = 4;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic          RST = 1'b1, ce = 1'b0, step_mode = 1'b0, step_in = 1'b0;
  logic [DW-1:0] in_port = '0;
  logic [DW-1:0] out_port, reg_a, reg_b;
  logic          carry_o, halted, retire;
  logic [DW+3:0] mem [16];

  tdx_core_if #(.DATA_W(DW), .PC_W(PW)) pb ();
  assign pb.prog_data = mem[pb.prog_addr];

  tdx_core #(.DATA_W(DW), .PC_W(PW)) dut (
    .CLK(CLK), .RST(RST), .ce(ce), .step_mode(step_mode), .step_in(step_in),
    .in_port(in_port), .pbus(pb), .out_port(out_port), .reg_a(reg_a),
    .reg_b(reg_b), .carry_o(carry_o), .halted(halted), .retire(retire));

  // 8-bit data instance
  logic       RST8 = 1'b1, ce8 = 1'b0, sm8 = 1'b0, st8 = 1'b0;
  logic [7:0] in8 = '0, out8, a8, b8;
  logic       c8, h8, r8;
  logic [11:0] mem8 [16];
  tdx_core_if #(.DATA_W(8), .PC_W(4)) pb8 ();
  assign pb8.prog_data = mem8[pb8.prog_addr];

  tdx_core #(.DATA_W(8), .PC_W(4)) dut8 (
    .CLK(CLK), .RST(RST8), .ce(ce8), .step_mode(sm8), .step_in(st8),
    .in_port(in8), .pbus(pb8), .out_port(out8), .reg_a(a8),
    .reg_b(b8), .carry_o(c8), .halted(h8), .retire(r8));

  typedef struct {int pc; int a; int b; int out; int c; int h;} exp_t;
  exp_t sbq[$];
  int errors = 0, checks = 0, n_ret = 0;
  int m_pc, m_a, m_b, m_out, m_c, m_h;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Instruction-level reference: one call = one executed instruction.
  task automatic model_exec(input int instr, input int inp);
    int op, im, y, sum;
    exp_t e;
    op = (instr >> 4) & 15;
    im = instr & 15;
    if (op == 8) m_h = 1;
    else begin
      if (op == 0 || op == 4)                y = m_a;
      else if (op == 1 || op == 5 || op == 9) y = m_b;
      else if (op == 2 || op == 6)           y = inp;
      else                                   y = 0;
      sum = y + im;
      if (op <= 3)                 m_a   = sum % 16;
      else if (op <= 7)            m_b   = sum % 16;
      else if (op == 9 || op == 11) m_out = sum % 16;
      if (op == 15 || (op == 14 && m_c == 0)) m_pc = sum % 16;
      else                                    m_pc = (m_pc + 1) % 16;
      m_c = (sum >= 16) ? 1 : 0;
    end
    e.pc = m_pc; e.a = m_a; e.b = m_b; e.out = m_out; e.c = m_c; e.h = m_h;
    sbq.push_back(e);
  endtask

  always @(negedge CLK) begin
    if (retire === 1'b1) begin
      n_ret++;
      if (sbq.size() == 0) chk("unexpected_retire", 1, 0);
      else begin
        exp_t e;
        e = sbq.pop_front();
        chk("ret_pc", int'(pb.prog_addr), e.pc);
        chk("ret_a", int'(reg_a), e.a);
        chk("ret_b", int'(reg_b), e.b);
        chk("ret_out", int'(out_port), e.out);
        chk("ret_carry", int'(carry_o), e.c);
        chk("ret_halted", int'(halted), e.h);
      end
    end
  end

  // Call aligned #1 after a posedge; leaves aligned likewise.
  task automatic do_reset();
    RST = 1'b1; ce = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b0;
    chk("pending_at_reset", sbq.size(), 0);
    sbq.delete();
    m_pc = 0; m_a = 0; m_b = 0; m_out = 0; m_c = 0; m_h = 0;
  endtask

  task automatic run(input int n, input bit c);
    for (int i = 0; i < n; i++) begin
      ce = c;
      if (c && !m_h) model_exec(int'(mem[m_pc]), int'(in_port));
      @(posedge CLK); #1;
    end
    ce = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pc"}, int'(pb.prog_addr), 0);
    chk({tag, "_a"}, int'(reg_a), 0);
    chk({tag, "_b"}, int'(reg_b), 0);
    chk({tag, "_out"}, int'(out_port), 0);
    chk({tag, "_carry"}, int'(carry_o), 0);
    chk({tag, "_halted"}, int'(halted), 0);
    chk({tag, "_retire"}, int'(retire), 0);
  endtask

  initial begin
    int r0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h80;
    @(posedge CLK); #1;
    do_reset();
    chk_zero("reset");

    // Straight-line program ending in HALT; extra execs must be ignored.
    mem[0] = 8'h33; mem[1] = 8'h05; mem[2] = 8'h0F; mem[3] = 8'hE0; mem[4] = 8'h80;
    run(9, 1'b1);
    chk("p1_a", int'(reg_a), 7);
    chk("p1_carry", int'(carry_o), 0);
    chk("p1_pc", int'(pb.prog_addr), 4);
    chk("p1_halted", int'(halted), 1);
    do_reset();
    chk_zero("rst_after_halt");
    run(2, 1'b1);

    // IN / OUT path
    mem[0] = 8'h60; mem[1] = 8'h90; mem[2] = 8'hB5; mem[3] = 8'h80;
    in_port = 4'hA;
    do_reset();
    run(3, 1'b1);
    chk("io_out", int'(out_port), 5);
    chk("io_b", int'(reg_b), 10);

    // NOP sweep: PC wraps after 16 instructions
    for (int i = 0; i < 16; i++) mem[i] = 8'hA0;
    do_reset();
    r0 = n_ret;
    run(16, 1'b1);
    @(negedge CLK); #1;
    chk("nop_retires", n_ret - r0, 16);
    chk("nop_pc_wrap", int'(pb.prog_addr), 0);
    chk("nop_a", int'(reg_a), 0);

    // Single step: ce ignored, held button gives one exec on the 3rd edge
    do_reset();
    step_mode = 1'b1; ce = 1'b1;
    repeat (3) begin @(posedge CLK); #1; end
    chk("step_ce_ignored", int'(pb.prog_addr), 0);
    r0 = n_ret;
    step_in = 1'b1;
    model_exec(int'(mem[m_pc]), int'(in_port));
    @(posedge CLK); #1; chk("step_edge1", int'(pb.prog_addr), 0);
    @(posedge CLK); #1; chk("step_edge2", int'(pb.prog_addr), 0);
    @(posedge CLK); #1; chk("step_edge3", int'(pb.prog_addr), 1);
    repeat (7) begin @(posedge CLK); #1; end
    step_in = 1'b0;
    repeat (4) begin @(posedge CLK); #1; end
    chk("step_one_retire", n_ret - r0, 1);
    chk("step_pc", int'(pb.prog_addr), 1);
    ce = 1'b0; step_mode = 1'b0;

    // Random programs, random ce and in_port, restart each round
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < 16; i++) mem[i] = 8'($urandom_range(0, 255));
      do_reset();
      for (int k = 0; k < 30; k++) begin
        in_port = 4'($urandom_range(0, 15));
        run(1, $urandom_range(0, 3) != 0);
      end
    end
    do_reset();

    // 8-bit datapath
    mem8[0] = 12'h302; mem8[1] = 12'h0FF; mem8[2] = 12'hF1C;
    for (int i = 3; i < 16; i++) mem8[i] = 12'h800;
    RST8 = 1'b1;
    @(posedge CLK); #1;
    RST8 = 1'b0; ce8 = 1'b1;
    @(posedge CLK); #1; chk("w8_mov_a", int'(a8), 2);
    @(posedge CLK); #1;
    chk("w8_add_a", int'(a8), 1);
    chk("w8_carry", int'(c8), 1);
    @(posedge CLK); #1;
    chk("w8_jmp_pc", int'(pb8.prog_addr), 12);
    ce8 = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
